// File: rtl/trng_health_mon.sv
// Online health monitor for an 8-bit TRNG stream. It runs the repetition-count and
// adaptive-proportion tests, gates a startup period, and forwards only healthy samples.
module trng_health_mon #(
    parameter int RCT_CUTOFF = 4,
    parameter int APT_WINDOW = 64,
    parameter int APT_CUTOFF = 16,
    parameter int STARTUP_N  = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       out_valid,
    output logic [7:0] out_data,
    input  logic       out_ready,
    input  logic       clear_alarm,
    output logic       rct_fail,
    output logic       apt_fail,
    output logic [1:0] state,
    output logic [7:0] fail_count
);

    localparam int RUN_W   = 4;
    localparam int WPOS_W  = $clog2(APT_WINDOW);
    localparam int MATCH_W = $clog2(APT_WINDOW + 1);
    localparam int SU_W    = $clog2(STARTUP_N + 1);

    typedef enum logic [1:0] {
        ST_STARTUP = 2'd0,
        ST_RUN     = 2'd1,
        ST_ALARM   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [RUN_W-1:0]    run_q;
    logic [7:0]          last_q;
    logic [WPOS_W-1:0]   wpos_q;
    logic [7:0]          ref_q;
    logic [MATCH_W-1:0]  match_q;
    logic [SU_W-1:0]     su_cnt_q;

    logic                accept, tested, rct_hit, apt_hit, any_fail, forward, startup_done;
    logic [RUN_W-1:0]    run_next;
    logic [MATCH_W-1:0]  match_next;

    assign in_ready = (state_q == ST_RUN) ? (!out_valid || out_ready) : 1'b1;
    assign state    = state_q;

    // A zero run length marks the first sample since startup entry, so it never matches last_q.
    assign accept       = in_valid && in_ready;
    assign tested       = accept && (state_q != ST_ALARM);
    assign run_next     = ((run_q != '0) && (in_data == last_q)) ? run_q + RUN_W'(1) : RUN_W'(1);
    assign match_next   = (wpos_q == '0) ? MATCH_W'(1)
                                         : match_q + MATCH_W'(in_data == ref_q);
    assign rct_hit      = tested && (run_next == RUN_W'(RCT_CUTOFF));
    assign apt_hit      = tested && (match_next == MATCH_W'(APT_CUTOFF));
    assign any_fail     = rct_hit || apt_hit;
    assign startup_done = (su_cnt_q == SU_W'(STARTUP_N - 1));
    assign forward      = tested && !any_fail && (state_q == ST_RUN);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_STARTUP;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_STARTUP: begin
                if (any_fail) begin
                    state_d = ST_ALARM;
                end else if (tested && startup_done) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (any_fail) begin
                    state_d = ST_ALARM;
                end
            end
            ST_ALARM: begin
                if (clear_alarm) begin
                    state_d = ST_STARTUP;
                end
            end
            default: state_d = ST_STARTUP;
        endcase
    end

    // Test statistics, sticky flags and the alarm counter; a clear restarts every statistic.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run_q      <= '0;
            last_q     <= '0;
            wpos_q     <= '0;
            ref_q      <= '0;
            match_q    <= '0;
            su_cnt_q   <= '0;
            rct_fail   <= 1'b0;
            apt_fail   <= 1'b0;
            fail_count <= '0;
        end else if ((state_q == ST_ALARM) && clear_alarm) begin
            run_q    <= '0;
            wpos_q   <= '0;
            match_q  <= '0;
            su_cnt_q <= '0;
            rct_fail <= 1'b0;
            apt_fail <= 1'b0;
        end else if (tested) begin
            run_q   <= run_next;
            last_q  <= in_data;
            wpos_q  <= wpos_q + WPOS_W'(1);
            match_q <= match_next;
            if (wpos_q == '0) begin
                ref_q <= in_data;
            end
            if (state_q == ST_STARTUP) begin
                su_cnt_q <= su_cnt_q + SU_W'(1);
            end
            if (rct_hit) begin
                rct_fail <= 1'b1;
            end
            if (apt_hit) begin
                apt_fail <= 1'b1;
            end
            if (any_fail && (fail_count != 8'hFF)) begin
                fail_count <= fail_count + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (forward) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_trng_health_mon.sv
// Randomised and directed bench for trng_health_mon against a history-based reference
// model that recomputes run lengths and window matches from the raw sample list.
module tb_trng_health_mon;

    localparam int RCT_CUTOFF = 4;
    localparam int APT_WINDOW = 64;
    localparam int APT_CUTOFF = 16;
    localparam int STARTUP_N  = 64;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready = 1'b0;
    logic       clear_alarm = 1'b0;
    logic       rct_fail, apt_fail;
    logic [1:0] state;
    logic [7:0] fail_count;

    trng_health_mon #(
        .RCT_CUTOFF(RCT_CUTOFF),
        .APT_WINDOW(APT_WINDOW),
        .APT_CUTOFF(APT_CUTOFF),
        .STARTUP_N (STARTUP_N)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .clear_alarm(clear_alarm),
        .rct_fail   (rct_fail),
        .apt_fail   (apt_fail),
        .state      (state),
        .fail_count (fail_count)
    );

    always #5 clk = ~clk;

    int         tests = 0;
    int         fails = 0;

    logic [1:0] m_state;
    logic       m_rct, m_apt, m_ov;
    logic [7:0] m_od, m_fc;
    logic [7:0] hist[$];
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    logic       dut_rdy_pre, mdl_rdy_pre;

    task automatic model_reset();
        m_state = 2'd0;
        m_rct   = 1'b0;
        m_apt   = 1'b0;
        m_ov    = 1'b0;
        m_od    = 8'h00;
        m_fc    = 8'h00;
        hist.delete();
        exp_q.delete();
        got_q.delete();
    endtask

    // One clock of stimulus; the model decides the cycle's outcome from the sample history.
    task automatic step(input logic v, input logic [7:0] d, input logic ordy, input logic clr);
        logic acc, fwd, rf, af;
        int   n, run, pos, ws, mt;
        @(negedge clk);
        in_valid    = v;
        in_data     = d;
        out_ready   = ordy;
        clear_alarm = clr;
        #1;
        mdl_rdy_pre = (m_state == 2'd1) ? (!m_ov || ordy) : 1'b1;
        dut_rdy_pre = in_ready;
        if (out_valid && ordy) got_q.push_back(out_data);
        acc = v && mdl_rdy_pre;
        fwd = 1'b0;
        if (m_state == 2'd2) begin
            if (clr) begin
                m_rct   = 1'b0;
                m_apt   = 1'b0;
                m_state = 2'd0;
                hist.delete();
            end
        end else if (acc) begin
            hist.push_back(d);
            n   = hist.size();
            run = 0;
            for (int i = n - 1; i >= 0; i--) begin
                if (hist[i] != d) break;
                run++;
            end
            rf  = (run == RCT_CUTOFF);
            pos = (n - 1) % APT_WINDOW;
            ws  = n - 1 - pos;
            mt  = 0;
            for (int i = ws; i < n; i++) if (hist[i] == hist[ws]) mt++;
            af  = (mt == APT_CUTOFF);
            if (rf || af) begin
                if (rf) m_rct = 1'b1;
                if (af) m_apt = 1'b1;
                if (m_fc != 8'hFF) m_fc = m_fc + 8'd1;
                m_state = 2'd2;
            end else if (m_state == 2'd0) begin
                if (n == STARTUP_N) m_state = 2'd1;
            end else begin
                fwd = 1'b1;
            end
        end
        if (fwd) begin
            m_ov = 1'b1;
            m_od = d;
            exp_q.push_back(d);
        end else if (ordy) begin
            m_ov = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #12;
        tests++; if (state !== 2'd0) begin fails++; $display("[TB] FAIL reset_state got %0d exp 0", state); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_out_valid got %b exp 0", out_valid); end
        tests++; if (out_data !== 8'h00) begin fails++; $display("[TB] FAIL reset_out_data got %h exp 00", out_data); end
        tests++; if (in_ready !== 1'b1) begin fails++; $display("[TB] FAIL reset_in_ready got %b exp 1", in_ready); end
        tests++; if ({rct_fail, apt_fail} !== 2'b00) begin fails++; $display("[TB] FAIL reset_flags got %b exp 00", {rct_fail, apt_fail}); end
        tests++; if (fail_count !== 8'h00) begin fails++; $display("[TB] FAIL reset_fail_count got %0d exp 0", fail_count); end
        @(negedge clk);
        reset = 1'b1;
        model_reset();
    endtask

    task automatic test_startup();
        for (int i = 0; i < 64; i++) begin
            step(1'b1, 8'(i), 1'b1, 1'b0);
            tests++; if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL startup_out_valid i=%0d got %b exp 0", i, out_valid); end
            tests++; if (state !== m_state) begin fails++; $display("[TB] FAIL startup_state i=%0d got %0d exp %0d", i, state, m_state); end
        end
        for (int k = 0; k < 2; k++) begin
            step(1'b1, 8'h40 + 8'(k), 1'b1, 1'b0);
            tests++; if (out_valid !== m_ov || out_data !== m_od) begin fails++; $display("[TB] FAIL first_forward k=%0d got %b/%h exp %b/%h", k, out_valid, out_data, m_ov, m_od); end
        end
    endtask

    task automatic test_back_pressure();
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 8'h50 + 8'(k), 1'b0, 1'b0);
            tests++; if (in_ready !== 1'b0) begin fails++; $display("[TB] FAIL bp_in_ready k=%0d got %b exp 0", k, in_ready); end
            tests++; if (out_valid !== 1'b1 || out_data !== 8'h41) begin fails++; $display("[TB] FAIL bp_hold k=%0d got %b/%h exp 1/41", k, out_valid, out_data); end
        end
        for (int k = 0; k < 4; k++) step(1'b1, 8'h60 + 8'(k), 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        tests++; if (got_q.size() != exp_q.size()) begin fails++; $display("[TB] FAIL bp_count got %0d exp %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            tests++; if (got_q[i] !== exp_q[i]) begin fails++; $display("[TB] FAIL bp_order i=%0d got %h exp %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_rct();
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 8'hA5, 1'b1, 1'b0);
            tests++; if (state !== m_state || rct_fail !== m_rct) begin fails++; $display("[TB] FAIL rct_progress k=%0d got %0d/%b exp %0d/%b", k, state, rct_fail, m_state, m_rct); end
        end
        tests++; if (rct_fail !== 1'b1 || apt_fail !== 1'b0) begin fails++; $display("[TB] FAIL rct_flags got %b%b exp 10", rct_fail, apt_fail); end
        tests++; if (state !== 2'd2) begin fails++; $display("[TB] FAIL rct_state got %0d exp 2", state); end
        tests++; if (fail_count !== 8'd1) begin fails++; $display("[TB] FAIL rct_fail_count got %0d exp 1", fail_count); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL rct_not_forwarded got %b exp 0", out_valid); end
    endtask

    task automatic test_alarm_clear();
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 8'h11, 1'b1, 1'b0);
            tests++; if (state !== 2'd2 || out_valid !== 1'b0) begin fails++; $display("[TB] FAIL alarm_discard k=%0d got %0d/%b exp 2/0", k, state, out_valid); end
        end
        step(1'b1, 8'h77, 1'b1, 1'b1);
        tests++; if (state !== 2'd0) begin fails++; $display("[TB] FAIL clear_state got %0d exp 0", state); end
        tests++; if ({rct_fail, apt_fail} !== 2'b00) begin fails++; $display("[TB] FAIL clear_flags got %b exp 00", {rct_fail, apt_fail}); end
        for (int i = 0; i < 64; i++) begin
            step(1'b1, 8'h80 + 8'(i), 1'b1, 1'b0);
            if (i == 62) begin
                tests++; if (state !== 2'd0) begin fails++; $display("[TB] FAIL restart_early got %0d exp 0", state); end
            end
        end
        tests++; if (state !== 2'd1) begin fails++; $display("[TB] FAIL restart_run got %0d exp 1", state); end
        tests++; if (fail_count !== 8'd1) begin fails++; $display("[TB] FAIL restart_fail_count got %0d exp 1", fail_count); end
    endtask

    task automatic test_apt();
        for (int k = 0; k < 16; k++) begin
            step(1'b1, 8'h3C, 1'b1, 1'b0);
            if (k < 15) begin
                tests++; if (apt_fail !== 1'b0 || state !== 2'd1) begin fails++; $display("[TB] FAIL apt_early k=%0d got %b/%0d exp 0/1", k, apt_fail, state); end
                step(1'b1, 8'h90 + 8'(k), 1'b1, 1'b0);
            end
        end
        tests++; if (apt_fail !== 1'b1 || rct_fail !== 1'b0) begin fails++; $display("[TB] FAIL apt_flags got %b%b exp 01", rct_fail, apt_fail); end
        tests++; if (state !== 2'd2 || fail_count !== 8'd2) begin fails++; $display("[TB] FAIL apt_alarm got %0d/%0d exp 2/2", state, fail_count); end
        tests++; if (apt_fail !== m_apt || fail_count !== m_fc) begin fails++; $display("[TB] FAIL apt_model got %b/%0d exp %b/%0d", apt_fail, fail_count, m_apt, m_fc); end
    endtask

    task automatic test_random();
        logic       v, o, c;
        logic [7:0] d;
        for (int n = 0; n < 1500; n++) begin
            v = ($urandom_range(0, 3) != 0);
            d = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 1)) : 8'($urandom);
            o = ($urandom_range(0, 3) != 0);
            c = (m_state == 2'd2) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 31) == 0);
            step(v, d, o, c);
            tests++; if (dut_rdy_pre !== mdl_rdy_pre) begin fails++; $display("[TB] FAIL rnd_in_ready n=%0d got %b exp %b", n, dut_rdy_pre, mdl_rdy_pre); end
            tests++; if (state !== m_state) begin fails++; $display("[TB] FAIL rnd_state n=%0d got %0d exp %0d", n, state, m_state); end
            tests++; if ({rct_fail, apt_fail} !== {m_rct, m_apt}) begin fails++; $display("[TB] FAIL rnd_flags n=%0d got %b%b exp %b%b", n, rct_fail, apt_fail, m_rct, m_apt); end
            tests++; if (fail_count !== m_fc) begin fails++; $display("[TB] FAIL rnd_fail_count n=%0d got %0d exp %0d", n, fail_count, m_fc); end
            tests++; if (out_valid !== m_ov || out_data !== m_od) begin fails++; $display("[TB] FAIL rnd_output n=%0d got %b/%h exp %b/%h", n, out_valid, out_data, m_ov, m_od); end
        end
    endtask

    task automatic test_reset_midstream();
        int guard;
        if (m_state == 2'd2) step(1'b0, 8'h00, 1'b1, 1'b1);
        guard = 0;
        while (m_state != 2'd1 && guard < 300) begin
            step(1'b1, 8'(guard), 1'b1, 1'b0);
            guard++;
        end
        tests++; if (m_state != 2'd1) begin fails++; $display("[TB] FAIL midreset_reach_run got %0d exp 1", m_state); end
        step(1'b1, 8'hC3, 1'b0, 1'b0);
        tests++; if (out_valid !== 1'b1) begin fails++; $display("[TB] FAIL midreset_pre_valid got %b exp 1", out_valid); end
        #2;
        reset = 1'b0;
        #1;
        tests++; if (out_valid !== 1'b0 || out_data !== 8'h00) begin fails++; $display("[TB] FAIL midreset_out got %b/%h exp 0/00", out_valid, out_data); end
        tests++; if (state !== 2'd0 || in_ready !== 1'b1) begin fails++; $display("[TB] FAIL midreset_state got %0d/%b exp 0/1", state, in_ready); end
        tests++; if ({rct_fail, apt_fail} !== 2'b00 || fail_count !== 8'h00) begin fails++; $display("[TB] FAIL midreset_counters got %b/%0d exp 00/0", {rct_fail, apt_fail}, fail_count); end
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        step(1'b1, 8'h5A, 1'b1, 1'b0);
        tests++; if (state !== m_state || out_valid !== 1'b0) begin fails++; $display("[TB] FAIL post_reset got %0d/%b exp %0d/0", state, out_valid, m_state); end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_startup();
        test_back_pressure();
        test_rct();
        test_alarm_clear();
        test_apt();
        test_random();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
